// File: rtl/timer_pkg.sv
// Shared constants for the timer peripheral family: bus base, register offsets,
// alarm configuration bit positions and the alarm FSM state type.
package timer_pkg;

    localparam logic [15:0] BASE_HI      = 16'h3FF5;

    localparam logic [15:0] OFF_ALARMLO  = 16'hF010;
    localparam logic [15:0] OFF_ALARMHI  = 16'hF014;
    localparam logic [15:0] OFF_PERIODLO = 16'hF028;
    localparam logic [15:0] OFF_PERIODHI = 16'hF02C;
    localparam logic [15:0] OFF_CFG      = 16'hF030;
    localparam logic [15:0] OFF_INT_ENA  = 16'hF098;
    localparam logic [15:0] OFF_INT_RAW  = 16'hF09C;
    localparam logic [15:0] OFF_INT_ST   = 16'hF0A0;
    localparam logic [15:0] OFF_INT_CLR  = 16'hF0A4;
    localparam logic [15:0] OFF_FIRE_CNT = 16'hF0A8;

    localparam int unsigned CFG_ARM   = 0;
    localparam int unsigned CFG_REARM = 1;
    localparam int unsigned CFG_DIR   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RELOAD = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/timer_alarm_cmp.sv
// Alarm comparator and re-arm adder, kept combinational and separate so a
// pipeline stage can be inserted here without touching the FSM.
module alarm_cmp #(
    parameter int unsigned CNT_W = 64
) (
    input  logic [CNT_W-1:0] counter,
    input  logic [CNT_W-1:0] alarm,
    input  logic [CNT_W-1:0] period,
    input  logic             dir,
    output logic             match,
    output logic [CNT_W-1:0] next_alarm
);

    always_comb begin
        match      = dir ? (counter >= alarm) : (counter <= alarm);
        next_alarm = dir ? (alarm + period) : (alarm - period);
    end

endmodule

// File: rtl/timer_alarm.sv
// Memory-mapped 64-bit alarm stage: compares the live timer count against a
// programmable alarm, latches an interrupt and optionally re-arms by a period.
module timer_alarm
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE_HI = timer_pkg::BASE_HI,
    parameter int unsigned CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      data_in,
    input  logic             wr_in,
    input  logic             rd_in,
    output logic             rd_valid_out,
    output logic [31:0]      data_out,
    input  logic [CNT_W-1:0] counter_in,
    output logic             irq_out
);

    alarm_state_t     state;
    logic [CNT_W-1:0] alarm;
    logic [CNT_W-1:0] period;
    logic [2:0]       cfg;
    logic             int_ena;
    logic             int_raw;
    logic [31:0]      fire_cnt;

    logic             hit;
    logic [15:0]      off;
    logic             wr_hit;
    logic             match;
    logic             fire;
    logic [CNT_W-1:0] next_alarm;
    logic [31:0]      rd_data;

    assign hit    = (addr_in[31:16] == BASE_HI);
    assign off    = addr_in[15:0];
    assign wr_hit = wr_in & hit;

    alarm_cmp #(.CNT_W(CNT_W)) u_cmp (
        .counter    (counter_in),
        .alarm      (alarm),
        .period     (period),
        .dir        (cfg[CFG_DIR]),
        .match      (match),
        .next_alarm (next_alarm)
    );

    assign fire    = (state == ARMED) && cfg[CFG_ARM] && match;
    assign irq_out = int_raw & int_ena;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= cfg[CFG_ARM] ? ARMED : IDLE;
                ARMED: begin
                    if (!cfg[CFG_ARM])
                        state <= IDLE;
                    else if (fire)
                        state <= cfg[CFG_REARM] ? RELOAD : IDLE;
                end
                RELOAD:  state <= cfg[CFG_ARM] ? ARMED : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Later assignments win: CPU writes override FSM updates on the same edge,
    // while a fire overrides a same-edge interrupt or counter clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm    <= '0;
            period   <= '0;
            cfg      <= '0;
            int_ena  <= 1'b0;
            int_raw  <= 1'b0;
            fire_cnt <= '0;
        end else begin
            if (fire && cfg[CFG_REARM])
                alarm <= next_alarm;
            if (fire && !cfg[CFG_REARM])
                cfg[CFG_ARM] <= 1'b0;
            if (wr_hit) begin
                case (off)
                    OFF_ALARMLO:  alarm[31:0]   <= data_in;
                    OFF_ALARMHI:  alarm[63:32]  <= data_in;
                    OFF_PERIODLO: period[31:0]  <= data_in;
                    OFF_PERIODHI: period[63:32] <= data_in;
                    OFF_CFG:      cfg           <= data_in[2:0];
                    OFF_INT_ENA:  int_ena       <= data_in[0];
                    OFF_INT_CLR:  if (data_in[0]) int_raw <= 1'b0;
                    OFF_FIRE_CNT: fire_cnt      <= '0;
                    default: ;
                endcase
            end
            if (fire) begin
                int_raw <= 1'b1;
                if (wr_hit && off == OFF_FIRE_CNT)
                    fire_cnt <= 32'd1;
                else if (fire_cnt != '1)
                    fire_cnt <= fire_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_ALARMLO:  rd_data = alarm[31:0];
            OFF_ALARMHI:  rd_data = alarm[63:32];
            OFF_PERIODLO: rd_data = period[31:0];
            OFF_PERIODHI: rd_data = period[63:32];
            OFF_CFG:      rd_data = {29'd0, cfg};
            OFF_INT_ENA:  rd_data = {31'd0, int_ena};
            OFF_INT_RAW:  rd_data = {31'd0, int_raw};
            OFF_INT_ST:   rd_data = {31'd0, int_raw & int_ena};
            OFF_FIRE_CNT: rd_data = fire_cnt;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_out <= 1'b0;
            data_out     <= '0;
        end else begin
            rd_valid_out <= rd_in & hit;
            if (rd_in && hit)
                data_out <= rd_data;
        end
    end

endmodule
